multicycle_control: RTL and testbench



---
 rtl/lc_isa_pkg.sv | 58 +++++
 rtl/opcode_classify.sv | 36 +++
 rtl/multicycle_control.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lc_isa_pkg.sv
// Shared LEGv8 subset definitions for the multicycle control unit:
// opcode match patterns, ALUOp encodings, FSM state and instruction class enums.
package lc_isa_pkg;

  // Each pattern is a value/care pair. A care bit of 0 is a don't-care position.
  localparam logic [10:0] OpAddiVal = 11'b10010001000;
  localparam logic [10:0] OpAddiCare = 11'b11111111110;
  localparam logic [10:0] OpAddsVal = 11'b10101011000;
  localparam logic [10:0] OpBVal = 11'b00010100000;
  localparam logic [10:0] OpBCare = 11'b11111100000;
  localparam logic [10:0] OpBltVal = 11'b01010100000;
  localparam logic [10:0] OpCbzVal = 11'b10110100000;
  localparam logic [10:0] OpBrCondCare = 11'b11111111000;
  localparam logic [10:0] OpLdurVal = 11'b11111000010;
  localparam logic [10:0] OpLslVal = 11'b11010011011;
  localparam logic [10:0] OpLsrVal = 11'b11010011010;
  localparam logic [10:0] OpMulVal = 11'b10011011000;
  localparam logic [10:0] OpSturVal = 11'b11111000000;
  localparam logic [10:0] OpSubsVal = 11'b11101011000;
  localparam logic [10:0] OpCareAll = 11'b11111111111;

  localparam logic [2:0] AluPass = 3'b000;
  localparam logic [2:0] AluShift = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b011;
  localparam logic [2:0] AluMul = 3'b111;

  typedef enum logic [2:0] {
    StFetch = 3'd0,
    StDecode = 3'd1,
    StExec = 3'd2,
    StMulWait = 3'd3,
    StMem = 3'd4,
    StWb = 3'd5,
    StTrap = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    ClsAddi,
    ClsAdds,
    ClsB,
    ClsBlt,
    ClsCbz,
    ClsLdur,
    ClsLsl,
    ClsLsr,
    ClsMul,
    ClsStur,
    ClsSubs,
    ClsIllegal
  } instr_class_t;

  function automatic logic op_match(input logic [10:0] op, input logic [10:0] val,
                                    input logic [10:0] care);
    return ((op ^ val) & care) == 11'd0;
  endfunction

endpackage

// File: rtl/opcode_classify.sv
// Combinational opcode classifier for the LEGv8 subset; anything unmatched,
// or MUL when the multiplier is disabled, classifies as illegal.
module opcode_classify
  import lc_isa_pkg::*;
#(
  parameter int unsigned OPCODE_W = 11,
  parameter bit ENABLE_MUL = 1'b1
) (
  input  logic [OPCODE_W-1:0] i_opcode,
  output instr_class_t        o_class,
  output logic                o_illegal
);

  instr_class_t w_class;

  always_comb begin
    w_class = ClsIllegal;
    if (op_match(i_opcode, OpAddiVal, OpAddiCare)) w_class = ClsAddi;
    else if (op_match(i_opcode, OpAddsVal, OpCareAll)) w_class = ClsAdds;
    else if (op_match(i_opcode, OpBVal, OpBCare)) w_class = ClsB;
    else if (op_match(i_opcode, OpBltVal, OpBrCondCare)) w_class = ClsBlt;
    else if (op_match(i_opcode, OpCbzVal, OpBrCondCare)) w_class = ClsCbz;
    else if (op_match(i_opcode, OpLdurVal, OpCareAll)) w_class = ClsLdur;
    else if (op_match(i_opcode, OpLslVal, OpCareAll)) w_class = ClsLsl;
    else if (op_match(i_opcode, OpLsrVal, OpCareAll)) w_class = ClsLsr;
    else if (op_match(i_opcode, OpMulVal, OpCareAll)) w_class = ClsMul;
    else if (op_match(i_opcode, OpSturVal, OpCareAll)) w_class = ClsStur;
    else if (op_match(i_opcode, OpSubsVal, OpCareAll)) w_class = ClsSubs;

    if (w_class == ClsMul && !ENABLE_MUL) w_class = ClsIllegal;
  end

  assign o_class   = w_class;
  assign o_illegal = (w_class == ClsIllegal);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle LEGv8 control FSM: FETCH/DECODE/EXEC/MUL_WAIT/MEM/WB with a
// memory-ready handshake, a counted multiply wait and a sticky illegal trap.
module multicycle_control
  import lc_isa_pkg::*;
#(
  parameter int unsigned OPCODE_W = 11,
  parameter int unsigned MUL_CYCLES = 4,
  parameter bit ENABLE_MUL = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                Reg2Loc,
  output logic                UBranch,
  output logic                Branch,
  output logic                MemtoReg,
  output logic                ALUsrc,
  output logic                RegWrite,
  output logic                ShiftDir,
  output logic [2:0]          ALUOp,
  output logic                flags_write,
  output logic                mul_start,
  output logic                retire,
  output logic                illegal,
  output logic [2:0]          state_dbg
);

  state_t       r_state;
  instr_class_t r_class;
  logic [7:0]   r_mul_cnt;

  instr_class_t w_class;
  logic         w_illegal;
  logic [2:0]   w_alu_op;
  logic         w_alu_src;
  logic         w_reg2loc;
  logic         w_shift_dir;

  opcode_classify #(
    .OPCODE_W  (OPCODE_W),
    .ENABLE_MUL(ENABLE_MUL)
  ) u_classify (
    .i_opcode (opcode),
    .o_class  (w_class),
    .o_illegal(w_illegal)
  );

  // Class is captured in DECODE so later states never look at the opcode input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StFetch;
      r_class   <= ClsIllegal;
      r_mul_cnt <= 8'd0;
    end else begin
      case (r_state)
        StFetch: if (mem_ready) r_state <= StDecode;
        StDecode: begin
          r_class <= w_class;
          r_state <= w_illegal ? StTrap : StExec;
        end
        StExec: begin
          case (r_class)
            ClsAddi, ClsAdds, ClsSubs, ClsLsl, ClsLsr: r_state <= StWb;
            ClsLdur, ClsStur: r_state <= StMem;
            ClsMul: begin
              r_mul_cnt <= 8'(MUL_CYCLES - 1);
              r_state   <= StMulWait;
            end
            ClsB, ClsBlt, ClsCbz: r_state <= StFetch;
            default: r_state <= StTrap;
          endcase
        end
        StMulWait: begin
          if (r_mul_cnt == 8'd0) r_state <= StWb;
          else r_mul_cnt <= r_mul_cnt - 8'd1;
        end
        StMem: if (mem_ready) r_state <= (r_class == ClsLdur) ? StWb : StFetch;
        StWb: r_state <= StFetch;
        StTrap: r_state <= StTrap;
        default: r_state <= StTrap;
      endcase
    end
  end

  // Single-cycle style datapath controls for the captured class.
  always_comb begin
    w_alu_op    = AluPass;
    w_alu_src   = 1'b0;
    w_reg2loc   = 1'b0;
    w_shift_dir = 1'b0;
    case (r_class)
      ClsAddi: begin
        w_alu_op  = AluAdd;
        w_alu_src = 1'b1;
      end
      ClsAdds: w_alu_op = AluAdd;
      ClsSubs: w_alu_op = AluSub;
      ClsLsl: begin
        w_alu_op  = AluShift;
        w_alu_src = 1'b1;
      end
      ClsLsr: begin
        w_alu_op    = AluShift;
        w_alu_src   = 1'b1;
        w_shift_dir = 1'b1;
      end
      ClsMul: w_alu_op = AluMul;
      ClsLdur: begin
        w_alu_op  = AluAdd;
        w_alu_src = 1'b1;
      end
      ClsStur: begin
        w_alu_op  = AluAdd;
        w_alu_src = 1'b1;
        w_reg2loc = 1'b1;
      end
      ClsCbz: w_reg2loc = 1'b1;
      default: ;
    endcase
  end

  // Holding reset forces every output low, independent of the clock.
  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    Reg2Loc     = 1'b0;
    UBranch     = 1'b0;
    Branch      = 1'b0;
    MemtoReg    = 1'b0;
    ALUsrc      = 1'b0;
    RegWrite    = 1'b0;
    ShiftDir    = 1'b0;
    ALUOp       = AluPass;
    flags_write = 1'b0;
    mul_start   = 1'b0;
    retire      = 1'b0;
    illegal     = 1'b0;
    if (reset_n) begin
      case (r_state)
        StFetch: begin
          mem_read = 1'b1;
          pc_write = mem_ready;
          ir_write = mem_ready;
        end
        StExec: begin
          ALUOp       = w_alu_op;
          ALUsrc      = w_alu_src;
          Reg2Loc     = w_reg2loc;
          ShiftDir    = w_shift_dir;
          flags_write = (r_class == ClsAdds) || (r_class == ClsSubs);
          mul_start   = (r_class == ClsMul);
          UBranch     = (r_class == ClsB);
          Branch      = (r_class == ClsBlt) || (r_class == ClsCbz);
          retire      = (r_class == ClsB) || (r_class == ClsBlt) || (r_class == ClsCbz);
        end
        StMulWait: ALUOp = AluMul;
        StMem: begin
          iord      = 1'b1;
          ALUsrc    = 1'b1;
          ALUOp     = AluAdd;
          Reg2Loc   = w_reg2loc;
          mem_read  = (r_class == ClsLdur);
          mem_write = (r_class == ClsStur);
          retire    = (r_class == ClsStur) && mem_ready;
        end
        StWb: begin
          RegWrite = 1'b1;
          MemtoReg = (r_class == ClsLdur);
          retire   = 1'b1;
          ALUOp    = w_alu_op;
          ALUsrc   = w_alu_src;
          ShiftDir = w_shift_dir;
        end
        StTrap: illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign state_dbg = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state and control-bus
// expectations for each instruction class, trap stickiness and async reset.
module tb_multicycle_control;

  logic        clk;
  logic        reset_n;
  logic [10:0] opcode;
  logic        mem_ready;

  logic pc_write, ir_write, iord, mem_read, mem_write;
  logic Reg2Loc, UBranch, Branch, MemtoReg, ALUsrc, RegWrite, ShiftDir;
  logic [2:0] ALUOp;
  logic flags_write, mul_start, retire, illegal;
  logic [2:0] state_dbg;

  logic nm_pc_write, nm_ir_write, nm_iord, nm_mem_read, nm_mem_write;
  logic nm_Reg2Loc, nm_UBranch, nm_Branch, nm_MemtoReg, nm_ALUsrc, nm_RegWrite, nm_ShiftDir;
  logic [2:0] nm_ALUOp;
  logic nm_flags_write, nm_mul_start, nm_retire, nm_illegal;
  logic [2:0] nm_state_dbg;

  // {pc_write, ir_write, iord, mem_read, mem_write, RegWrite, MemtoReg, retire}
  logic [7:0] bus;
  assign bus = {pc_write, ir_write, iord, mem_read, mem_write, RegWrite, MemtoReg, retire};

  int n_checks = 0;
  int n_errors = 0;
  bit pending  = 1'b0;

  multicycle_control dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .Reg2Loc(Reg2Loc), .UBranch(UBranch), .Branch(Branch),
    .MemtoReg(MemtoReg), .ALUsrc(ALUsrc), .RegWrite(RegWrite), .ShiftDir(ShiftDir),
    .ALUOp(ALUOp), .flags_write(flags_write), .mul_start(mul_start), .retire(retire),
    .illegal(illegal), .state_dbg(state_dbg)
  );

  multicycle_control #(.ENABLE_MUL(1'b0)) dut_nm (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(nm_pc_write), .ir_write(nm_ir_write), .iord(nm_iord), .mem_read(nm_mem_read),
    .mem_write(nm_mem_write), .Reg2Loc(nm_Reg2Loc), .UBranch(nm_UBranch),
    .Branch(nm_Branch), .MemtoReg(nm_MemtoReg), .ALUsrc(nm_ALUsrc),
    .RegWrite(nm_RegWrite), .ShiftDir(nm_ShiftDir), .ALUOp(nm_ALUOp),
    .flags_write(nm_flags_write), .mul_start(nm_mul_start), .retire(nm_retire),
    .illegal(nm_illegal), .state_dbg(nm_state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Assert reset, check the quiescent outputs, release mid-cycle into cycle 1.
  task automatic do_reset(input logic [10:0] op);
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    opcode    = op;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_bus", {24'd0, bus}, 32'h00);
    check_eq("rst_state", {29'd0, state_dbg}, 32'd0);
    check_eq("rst_illegal", {31'd0, illegal}, 32'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    pending = 1'b0;
  endtask

  // One clock cycle: drive mem_ready, sample at the falling edge.
  task automatic step(input string tag, input logic rdy, input logic [2:0] st,
                      input logic [7:0] exp_bus);
    if (pending) begin
      @(posedge clk);
      #2;
    end
    pending   = 1'b1;
    mem_ready = rdy;
    @(negedge clk);
    check_eq({tag, "_state"}, {29'd0, state_dbg}, {29'd0, st});
    check_eq({tag, "_bus"}, {24'd0, bus}, {24'd0, exp_bus});
  endtask

  // Run an ALU op with mem_ready high and check its EXEC controls.
  task automatic alu_exec(input string tag, input logic [10:0] op, input logic [2:0] aop,
                          input logic src, input logic sdir, input logic fw);
    do_reset(op);
    step({tag, "_c1"}, 1'b1, 3'd0, 8'b11010000);
    step({tag, "_c2"}, 1'b1, 3'd1, 8'b00000000);
    step({tag, "_c3"}, 1'b1, 3'd2, 8'b00000000);
    check_eq({tag, "_aluop"}, {29'd0, ALUOp}, {29'd0, aop});
    check_eq({tag, "_alusrc"}, {31'd0, ALUsrc}, {31'd0, src});
    check_eq({tag, "_shiftdir"}, {31'd0, ShiftDir}, {31'd0, sdir});
    check_eq({tag, "_flagsw"}, {31'd0, flags_write}, {31'd0, fw});
    step({tag, "_c4"}, 1'b1, 3'd5, 8'b00000101);
    step({tag, "_c5"}, 1'b1, 3'd0, 8'b11010000);
  endtask

  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    opcode    = 11'd0;

    // ADDI and the other ALU ops: 4 cycles, RegWrite/retire only in WB.
    alu_exec("addi", 11'b10010001000, 3'b010, 1'b1, 1'b0, 1'b0);
    alu_exec("addi_x", 11'b10010001001, 3'b010, 1'b1, 1'b0, 1'b0);
    alu_exec("subs", 11'b11101011000, 3'b011, 1'b0, 1'b0, 1'b1);
    alu_exec("adds", 11'b10101011000, 3'b010, 1'b0, 1'b0, 1'b1);
    alu_exec("lsr", 11'b11010011010, 3'b001, 1'b1, 1'b1, 1'b0);
    alu_exec("lsl", 11'b11010011011, 3'b001, 1'b1, 1'b0, 1'b0);

    // LDUR with two memory wait cycles: 7 cycles total.
    do_reset(11'b11111000010);
    step("ldur_c1", 1'b1, 3'd0, 8'b11010000);
    step("ldur_c2", 1'b1, 3'd1, 8'b00000000);
    step("ldur_c3", 1'b0, 3'd2, 8'b00000000);
    step("ldur_c4", 1'b0, 3'd4, 8'b00110000);
    check_eq("ldur_mem_aluop", {29'd0, ALUOp}, 32'd2);
    check_eq("ldur_mem_alusrc", {31'd0, ALUsrc}, 32'd1);
    step("ldur_c5", 1'b0, 3'd4, 8'b00110000);
    step("ldur_c6", 1'b1, 3'd4, 8'b00110000);
    step("ldur_c7", 1'b0, 3'd5, 8'b00000111);
    step("ldur_c8", 1'b0, 3'd0, 8'b00010000);

    // MUL: start pulse in EXEC, 4 MUL_WAIT cycles, WB in cycle 8.
    do_reset(11'b10011011000);
    step("mul_c1", 1'b1, 3'd0, 8'b11010000);
    step("mul_c2", 1'b1, 3'd1, 8'b00000000);
    step("mul_c3", 1'b1, 3'd2, 8'b00000000);
    check_eq("mul_start", {31'd0, mul_start}, 32'd1);
    check_eq("mul_exec_aluop", {29'd0, ALUOp}, 32'd7);
    check_eq("nomul_state", {29'd0, nm_state_dbg}, 32'd7);
    check_eq("nomul_illegal", {31'd0, nm_illegal}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step("mul_wait", 1'b1, 3'd3, 8'b00000000);
      check_eq("mul_wait_aluop", {29'd0, ALUOp}, 32'd7);
      check_eq("mul_wait_start", {31'd0, mul_start}, 32'd0);
    end
    step("mul_wb", 1'b1, 3'd5, 8'b00000101);
    check_eq("mul_wb_aluop", {29'd0, ALUOp}, 32'd7);
    step("mul_done", 1'b1, 3'd0, 8'b11010000);

    // B then CBZ: 3 cycles each, branch enables in EXEC, no RegWrite.
    do_reset(11'b00010100000);
    step("b_c1", 1'b1, 3'd0, 8'b11010000);
    step("b_c2", 1'b1, 3'd1, 8'b00000000);
    step("b_c3", 1'b1, 3'd2, 8'b00000001);
    check_eq("b_ubranch", {31'd0, UBranch}, 32'd1);
    check_eq("b_branch", {31'd0, Branch}, 32'd0);
    opcode = 11'b10110100101;
    step("cbz_c1", 1'b1, 3'd0, 8'b11010000);
    step("cbz_c2", 1'b1, 3'd1, 8'b00000000);
    step("cbz_c3", 1'b1, 3'd2, 8'b00000001);
    check_eq("cbz_branch", {31'd0, Branch}, 32'd1);
    check_eq("cbz_reg2loc", {31'd0, Reg2Loc}, 32'd1);
    check_eq("cbz_aluop", {29'd0, ALUOp}, 32'd0);
    check_eq("cbz_ubranch", {31'd0, UBranch}, 32'd0);
    opcode = 11'b01010100011;
    step("blt_c1", 1'b1, 3'd0, 8'b11010000);
    step("blt_c2", 1'b1, 3'd1, 8'b00000000);
    step("blt_c3", 1'b1, 3'd2, 8'b00000001);
    check_eq("blt_branch", {31'd0, Branch}, 32'd1);
    step("blt_c4", 1'b0, 3'd0, 8'b00010000);

    // Fetch stall: no pc/ir write until mem_ready.
    do_reset(11'b11111000000);
    step("stur_c1", 1'b0, 3'd0, 8'b00010000);
    step("stur_c2", 1'b1, 3'd0, 8'b11010000);
    step("stur_c3", 1'b1, 3'd1, 8'b00000000);
    step("stur_c4", 1'b1, 3'd2, 8'b00000000);
    check_eq("stur_reg2loc", {31'd0, Reg2Loc}, 32'd1);
    step("stur_c5", 1'b1, 3'd4, 8'b00101001);
    step("stur_c6", 1'b1, 3'd0, 8'b11010000);

    // Illegal opcode: trap from cycle 3, sticky, cleared asynchronously.
    do_reset(11'b00000000000);
    step("ill_c1", 1'b1, 3'd0, 8'b11010000);
    step("ill_c2", 1'b1, 3'd1, 8'b00000000);
    step("ill_c3", 1'b0, 3'd7, 8'b00000000);
    check_eq("ill_flag", {31'd0, illegal}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      step("ill_hold", logic'(i[0]), 3'd7, 8'b00000000);
      check_eq("ill_hold_flag", {31'd0, illegal}, 32'd1);
    end
    #1 reset_n = 1'b0;
    #1;
    check_eq("ill_async_clear", {31'd0, illegal}, 32'd0);
    check_eq("ill_async_state", {29'd0, state_dbg}, 32'd0);

    // Reset during a STUR memory wait drops mem_write without a clock edge.
    do_reset(11'b11111000000);
    step("sturw_c1", 1'b1, 3'd0, 8'b11010000);
    step("sturw_c2", 1'b1, 3'd1, 8'b00000000);
    step("sturw_c3", 1'b0, 3'd2, 8'b00000000);
    step("sturw_c4", 1'b0, 3'd4, 8'b00101000);
    step("sturw_c5", 1'b0, 3'd4, 8'b00101000);
    #1 reset_n = 1'b0;
    #1;
    check_eq("sturw_async_wr", {31'd0, mem_write}, 32'd0);
    check_eq("sturw_async_bus", {24'd0, bus}, 32'h00);
    check_eq("sturw_async_state", {29'd0, state_dbg}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    pending = 1'b0;
    step("sturw_post", 1'b0, 3'd0, 8'b00010000);
    step("sturw_post2", 1'b0, 3'd0, 8'b00010000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
